row_norm_seq: RTL

- Sequential, parametrised successor to the combinational per-row sqrt/divide normaliser in the fastica symmetric-orthogonalisation path.
- Accepts an N x N signed fixed-point matrix plus N per-row sums of squares, and divides every row by the square root of its sum.
- Uses one shared iterative integer square root and one restoring divider instead of N*N parallel dividers.
- Uses valid/ready handshakes, per-row saturation and zero-sum flags, and a bypass mode that replaces the old enable-low pass-through.

---
 rtl/row_norm_seq.sv | 224 ++++++++++++++++++++++
 1 files changed

// File: rtl/row_norm_seq.sv
// Sequential row normaliser: divides each row of an N x N Q(FRAC) matrix by the
// square root of its sum of squares, sharing one bit-serial sqrt and one divider.
module row_norm_seq #(
  parameter int N    = 4,
  parameter int W    = 26,
  parameter int FRAC = 12
) (
  input  logic               clk_norm,
  input  logic               rst_n_norm,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               bypass,
  input  logic [N*N*W-1:0]   mat_in,
  input  logic [N*W-1:0]     sum_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [N*N*W-1:0]   mat_out,
  output logic [N-1:0]       sat_flag,
  output logic [N-1:0]       zero_flag
);

  localparam int RW     = W + FRAC;
  localparam int SQ_IT  = (RW + 1) / 2;
  localparam int DIV_IT = RW;
  localparam int SW     = SQ_IT;
  localparam int RADW   = 2 * SQ_IT;
  localparam int CW     = $clog2(DIV_IT + 1);
  localparam int IW     = (N > 1) ? $clog2(N) : 1;
  localparam logic [W-1:0] MAX_POS = {1'b0, {(W-1){1'b1}}};

  typedef enum logic [1:0] {IDLE, SQRT, DIV, DONE} state_t;

  state_t             state_reg;
  logic [N*N*W-1:0]   mat_reg;
  logic [N*W-1:0]     sum_reg;
  logic               byp_reg;
  logic [IW-1:0]      row_reg;
  logic [IW-1:0]      col_reg;
  logic [CW-1:0]      cnt_reg;
  logic [RADW-1:0]    rad_reg;
  logic [SW:0]        rsq_reg;
  logic [SW-1:0]      root_reg;
  logic [RW-1:0]      dvd_reg;
  logic [RW-1:0]      quo_reg;
  logic [SW-1:0]      rdv_reg;

  logic [W-1:0]       sum_arr [N];
  logic [W-1:0]       elem_arr [N*N];

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_sum
      assign sum_arr[gi] = sum_reg[gi*W +: W];
    end
    for (gi = 0; gi < N*N; gi++) begin : g_elem
      assign elem_arr[gi] = mat_reg[gi*W +: W];
    end
  endgenerate

  logic [W-1:0]    sum_cur, elem_cur, sum_pos, abs_x;
  logic            row_zero, first, last_sq, last_dv, last_col, last_row;
  logic [RADW-1:0] rad_src, rad_next;
  logic [SW:0]     rsq_src, rsq_next;
  logic [SW-1:0]   root_src, root_next;
  logic [SW+2:0]   rem4, trial;
  logic            sq_ge, dv_ge;
  logic [RW-1:0]   dvd_src, dvd_next, quo_src, quo_next;
  logic [SW-1:0]   rdv_src, rdv_next;
  logic [SW:0]     rem2, dvx;
  logic            res_sat;
  logic [W-1:0]    res_mag, res_val;

  always_comb begin
    sum_cur  = '0;
    elem_cur = '0;
    for (int r = 0; r < N; r++) begin
      if (row_reg == IW'(r)) sum_cur = sum_arr[r];
      for (int c = 0; c < N; c++) begin
        if (row_reg == IW'(r) && col_reg == IW'(c)) elem_cur = elem_arr[r*N+c];
      end
    end
    sum_pos  = sum_cur[W-1] ? '0 : sum_cur;
    row_zero = sum_cur[W-1] || (sum_cur == '0);
    first    = (cnt_reg == '0);
    last_sq  = (cnt_reg == CW'(SQ_IT - 1));
    last_dv  = (cnt_reg == CW'(DIV_IT - 1));
    last_col = (col_reg == IW'(N - 1));
    last_row = (row_reg == IW'(N - 1));

    // Digit-by-digit square root: two radicand bits per cycle, one root bit out.
    rad_src   = first ? (RADW'(sum_pos) << FRAC) : rad_reg;
    rsq_src   = first ? '0 : rsq_reg;
    root_src  = first ? '0 : root_reg;
    rem4      = {rsq_src, rad_src[RADW-1 -: 2]};
    trial     = {1'b0, root_src, 2'b01};
    sq_ge     = (rem4 >= trial);
    rsq_next  = (SW+1)'(sq_ge ? rem4 - trial : rem4);
    root_next = (root_src << 1) | SW'(sq_ge);
    rad_next  = rad_src << 2;

    // Restoring division of |x| << FRAC by the row root held in root_reg.
    abs_x    = elem_cur[W-1] ? (~elem_cur + 1'b1) : elem_cur;
    dvd_src  = first ? {abs_x, {FRAC{1'b0}}} : dvd_reg;
    rdv_src  = first ? '0 : rdv_reg;
    quo_src  = first ? '0 : quo_reg;
    rem2     = {rdv_src, dvd_src[RW-1]};
    dvx      = {1'b0, root_reg};
    dv_ge    = (rem2 >= dvx);
    rdv_next = SW'(dv_ge ? rem2 - dvx : rem2);
    quo_next = (quo_src << 1) | RW'(dv_ge);
    dvd_next = dvd_src << 1;

    res_sat = (quo_next > RW'(MAX_POS));
    res_mag = res_sat ? MAX_POS : quo_next[W-1:0];
    res_val = elem_cur[W-1] ? (~res_mag + 1'b1) : res_mag;
  end

  always_ff @(posedge clk_norm or negedge rst_n_norm) begin
    if (!rst_n_norm) begin
      state_reg <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      mat_out   <= '0;
      sat_flag  <= '0;
      zero_flag <= '0;
      mat_reg   <= '0;
      sum_reg   <= '0;
      byp_reg   <= 1'b0;
      row_reg   <= '0;
      col_reg   <= '0;
      cnt_reg   <= '0;
      rad_reg   <= '0;
      rsq_reg   <= '0;
      root_reg  <= '0;
      dvd_reg   <= '0;
      quo_reg   <= '0;
      rdv_reg   <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            mat_reg   <= mat_in;
            sum_reg   <= sum_in;
            byp_reg   <= bypass;
            in_ready  <= 1'b0;
            sat_flag  <= '0;
            zero_flag <= '0;
            row_reg   <= '0;
            col_reg   <= '0;
            cnt_reg   <= '0;
            state_reg <= bypass ? DONE : SQRT;
          end
        end
        SQRT: begin
          rad_reg  <= rad_next;
          rsq_reg  <= rsq_next;
          root_reg <= root_next;
          cnt_reg  <= cnt_reg + CW'(1);
          if (last_sq) begin
            cnt_reg <= '0;
            col_reg <= '0;
            if (row_zero) begin
              // Non-positive sum: the row is copied and its divisions skipped.
              for (int r = 0; r < N; r++) begin
                if (row_reg == IW'(r)) begin
                  mat_out[r*N*W +: N*W] <= mat_reg[r*N*W +: N*W];
                  zero_flag[r]          <= 1'b1;
                end
              end
              if (last_row) begin
                state_reg <= DONE;
              end else begin
                row_reg   <= row_reg + IW'(1);
                state_reg <= SQRT;
              end
            end else begin
              state_reg <= DIV;
            end
          end
        end
        DIV: begin
          dvd_reg <= dvd_next;
          rdv_reg <= rdv_next;
          quo_reg <= quo_next;
          cnt_reg <= cnt_reg + CW'(1);
          if (last_dv) begin
            cnt_reg <= '0;
            for (int r = 0; r < N; r++) begin
              if (row_reg == IW'(r)) begin
                if (res_sat) sat_flag[r] <= 1'b1;
                for (int c = 0; c < N; c++) begin
                  if (col_reg == IW'(c)) mat_out[(r*N+c)*W +: W] <= res_val;
                end
              end
            end
            if (!last_col) begin
              col_reg <= col_reg + IW'(1);
            end else begin
              col_reg <= '0;
              if (last_row) begin
                state_reg <= DONE;
              end else begin
                row_reg   <= row_reg + IW'(1);
                state_reg <= SQRT;
              end
            end
          end
        end
        DONE: begin
          if (!out_valid) begin
            out_valid <= 1'b1;
            if (byp_reg) mat_out <= mat_reg;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule
